// File: rtl/sort_checker_pkg.sv
// sort_checker_pkg: shared state encoding and constants for the sort checker
package sort_checker_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int RESP_OKAY = 0;
  function automatic int sum_wdth(input int data_wdth, input int addr_wdth);
    return data_wdth + addr_wdth + 1;
  endfunction
endpackage

// File: rtl/sort_checker_if.sv
// sort_checker_if: read-channel bundle (AR + R) between a requester and memory
interface sort_checker_if #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
);
  logic                 ar_valid;
  logic                 ar_ready;
  logic [ADDR_WDTH-1:0] ar_address;
  logic                 r_valid;
  logic                 r_ready;
  logic [DATA_WDTH-1:0] r_data;
  logic [RESP_WDTH-1:0] r_resp;
  modport master (output ar_valid, ar_address, r_ready, input ar_ready, r_valid, r_data, r_resp);
  modport slave  (input ar_valid, ar_address, r_ready, output ar_ready, r_valid, r_data, r_resp);
endinterface

// File: rtl/sort_order_cmp.sv
// sort_order_cmp: flags an out-of-order neighbour pair (equal values are legal)
module sort_order_cmp #(
  parameter int DATA_WDTH  = 32,
  parameter int SIGNED     = 0,
  parameter int DESCENDING = 0
) (
  input  logic [DATA_WDTH-1:0] prev,
  input  logic [DATA_WDTH-1:0] cur,
  output logic                 violation
);
  logic lt, gt;
  always_comb begin
    lt = (SIGNED != 0) ? ($signed(cur) < $signed(prev)) : (cur < prev);
    gt = (SIGNED != 0) ? ($signed(cur) > $signed(prev)) : (cur > prev);
    violation = (DESCENDING != 0) ? gt : lt;
  end
endmodule

// File: rtl/sort_checker.sv
// sort_checker: read-channel passthrough that can take over memory to verify order and checksum
module sort_checker
  import sort_checker_pkg::*;
#(
  parameter int ADDR_WDTH  = 4,
  parameter int DATA_WDTH  = 32,
  parameter int RESP_WDTH  = 1,
  parameter int SIGNED     = 0,
  parameter int DESCENDING = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_WDTH:0]   arr_size,
  input  logic                 chk_start,
  input  logic                 chk_post,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 err_order,
  output logic                 err_sum,
  output logic                 err_resp,
  output logic [ADDR_WDTH-1:0] fail_idx,
  sort_checker_if.slave        s,
  sort_checker_if.master       m
);
  localparam int SW = sum_wdth(DATA_WDTH, ADDR_WDTH);
  localparam logic [ADDR_WDTH:0] ONE   = (ADDR_WDTH+1)'(1);
  localparam logic [ADDR_WDTH:0] DEPTH = ONE << ADDR_WDTH;

  logic [1:0]           st;
  logic                 s_pend, post;
  logic [ADDR_WDTH:0]   n, idx, n_in;
  logic [DATA_WDTH-1:0] prev;
  logic [SW-1:0]        sum, ref_sum, sum_nxt, ext;
  logic                 idle, accept, beat, bad, viol_raw, viol;
  logic                 eo_nxt, er_nxt, es_nxt, post_nxt, fin;

  assign idle = st == S_IDLE;
  assign busy = !idle;
  assign done = st == S_DONE;

  // While idle the sorter sees memory directly; otherwise the checker owns the channel.
  assign m.ar_valid   = idle ? s.ar_valid : st == S_ADDR;
  assign m.ar_address = idle ? s.ar_address : idx[ADDR_WDTH-1:0];
  assign m.r_ready    = idle ? s.r_ready : st == S_DATA;
  assign s.ar_ready   = idle & m.ar_ready;
  assign s.r_valid    = idle & m.r_valid;
  assign s.r_data     = m.r_data;
  assign s.r_resp     = m.r_resp;

  sort_order_cmp #(
    .DATA_WDTH (DATA_WDTH),
    .SIGNED    (SIGNED),
    .DESCENDING(DESCENDING)
  ) u_cmp (
    .prev     (prev),
    .cur      (m.r_data),
    .violation(viol_raw)
  );

  // Final flags are computed on the way into DONE so they are valid alongside the done pulse.
  always_comb begin
    n_in     = arr_size > DEPTH ? DEPTH : arr_size;
    accept   = idle && chk_start && !s_pend;
    beat     = st == S_DATA && m.r_valid;
    bad      = m.r_resp != RESP_WDTH'(RESP_OKAY);
    ext      = {{(SW-DATA_WDTH){SIGNED != 0 && m.r_data[DATA_WDTH-1]}}, m.r_data};
    viol     = beat && !bad && idx != '0 && post && !err_order && viol_raw;
    sum_nxt  = idle ? '0 : (beat && !bad) ? sum + ext : sum;
    eo_nxt   = !idle && (err_order || viol);
    er_nxt   = !idle && (err_resp || (beat && bad));
    post_nxt = idle ? chk_post : post;
    es_nxt   = post_nxt && sum_nxt != ref_sum;
    fin      = accept ? n_in == '0 : beat && (bad || idx + ONE == n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      s_pend    <= 1'b0;
      post      <= 1'b0;
      n         <= '0;
      idx       <= '0;
      prev      <= '0;
      sum       <= '0;
      ref_sum   <= '0;
      pass      <= 1'b0;
      err_order <= 1'b0;
      err_sum   <= 1'b0;
      err_resp  <= 1'b0;
      fail_idx  <= '0;
    end else begin
      if (s.ar_valid && s.ar_ready) s_pend <= 1'b1;
      else if (s.r_valid && s.r_ready) s_pend <= 1'b0;
      if (accept || beat) begin
        sum       <= sum_nxt;
        err_order <= eo_nxt;
        err_resp  <= er_nxt;
      end
      if (accept) begin
        post     <= chk_post;
        n        <= n_in;
        idx      <= '0;
        fail_idx <= '0;
        err_sum  <= 1'b0;
        pass     <= 1'b0;
      end
      if (viol) fail_idx <= idx[ADDR_WDTH-1:0];
      if (beat) begin
        prev <= m.r_data;
        idx  <= idx + ONE;
      end
      if (fin) begin
        err_sum <= es_nxt;
        pass    <= !(eo_nxt || es_nxt || er_nxt);
        if (!post_nxt) ref_sum <= sum_nxt;
      end
      st <= accept ? (n_in == '0 ? S_DONE : S_ADDR) :
            st == S_ADDR ? (m.ar_ready ? S_DATA : S_ADDR) :
            beat ? (fin ? S_DONE : S_ADDR) :
            st == S_DONE ? S_IDLE : st;
    end
  end
endmodule

// File: tb/tb_sort_checker.sv
// tb_sort_checker: scoreboard bench for an unsigned and a signed checker on zero-wait memories
module tb_sort_checker;
  typedef struct {
    int dut;
    bit pass, eo, es, er;
    int fidx;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] chk_start, chk_post, busy, done, pass, err_order, err_sum, err_resp;
  logic [4:0] arr_size [2];
  logic [3:0] fail_idx [2];
  logic [31:0] ram [16];
  bit always_error;
  logic rv0, rv1;
  logic [31:0] rd0, rd1;

  sort_checker_if #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1)) s0 (), m0 (), s1 (), m1 ();

  assign m0.ar_ready = 1'b1;
  assign m0.r_valid  = rv0;
  assign m0.r_data   = rd0;
  assign m0.r_resp   = always_error;
  assign m1.ar_ready = 1'b1;
  assign m1.r_valid  = rv1;
  assign m1.r_data   = rd1;
  assign m1.r_resp   = always_error;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rv0 <= 1'b0;
    else begin
      if (m0.r_valid && m0.r_ready) rv0 <= 1'b0;
      if (m0.ar_valid && m0.ar_ready) begin
        rv0 <= 1'b1;
        rd0 <= ram[m0.ar_address];
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rv1 <= 1'b0;
    else begin
      if (m1.r_valid && m1.r_ready) rv1 <= 1'b0;
      if (m1.ar_valid && m1.ar_ready) begin
        rv1 <= 1'b1;
        rd1 <= ram[m1.ar_address];
      end
    end
  end

  sort_checker #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .SIGNED(0), .DESCENDING(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .arr_size(arr_size[0]), .chk_start(chk_start[0]), .chk_post(chk_post[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_order(err_order[0]), .err_sum(err_sum[0]),
    .err_resp(err_resp[0]), .fail_idx(fail_idx[0]), .s(s0), .m(m0));

  sort_checker #(.ADDR_WDTH(4), .DATA_WDTH(32), .RESP_WDTH(1), .SIGNED(1), .DESCENDING(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .arr_size(arr_size[1]), .chk_start(chk_start[1]), .chk_post(chk_post[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_order(err_order[1]), .err_sum(err_sum[1]),
    .err_resp(err_resp[1]), .fail_idx(fail_idx[1]), .s(s1), .m(m1));

  exp_t q [$];
  exp_t mon_e;
  longint ref_sum [2];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 [2];
  bit [1:0] busy_q;
  int own_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour: reads what the scan will read and tracks the stored pre-scan sum.
  function automatic exp_t model(input int g, input bit post, input int size);
    exp_t e;
    longint s = 0;
    int n = size > 16 ? 16 : size;
    e.dut = g; e.eo = 0; e.er = 0; e.fidx = 0;
    if (n > 0 && always_error) begin
      e.er = 1;
      e.cyc = 3;
    end else begin
      for (int i = 0; i < n; i++) begin
        longint v;
        v = g != 0 ? longint'($signed(ram[i])) : longint'(ram[i]);
        if (post && i > 0 && !e.eo && (g != 0 ? $signed(ram[i]) < $signed(ram[i-1]) : ram[i] < ram[i-1])) begin
          e.eo = 1;
          e.fidx = i;
        end
        s += v;
      end
      e.cyc = 2 * n + 1;
    end
    e.es = post && s != ref_sum[g];
    if (!post) ref_sum[g] = s;
    e.pass = !(e.eo || e.es || e.er);
    return e;
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (busy[g] && !busy_q[g]) t0[g] = cyc;
      busy_q[g] = busy[g];
      if (done[g]) begin
        if (q.size() == 0) check("spurious_done", 1, 0);
        else begin
          mon_e = q.pop_front();
          check("done_dut", g, mon_e.dut);
          check("pass", pass[g], mon_e.pass);
          check("err_order", err_order[g], mon_e.eo);
          check("err_sum", err_sum[g], mon_e.es);
          check("err_resp", err_resp[g], mon_e.er);
          if (mon_e.eo) check("fail_idx", fail_idx[g], mon_e.fidx);
          check("done_cycle", cyc - t0[g] + 1, mon_e.cyc);
        end
      end
    end
    if (busy[0] && (s0.ar_ready || s0.r_valid)) own_bad++;
  end

  task automatic scan(input int g, input bit post, input int size);
    bit ok = 0;
    q.push_back(model(g, post, size));
    @(negedge clk);
    chk_start[g] = 1'b1;
    chk_post[g] = post;
    arr_size[g] = 5'(size);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = busy[g];
    end
    chk_start[g] = 1'b0;
    if (!ok) begin
      check("accept_timeout", 1, 0);
      q.delete();
      return;
    end
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = q.size() == 0;
      if (!ok) @(negedge clk);
    end
    if (!ok) begin
      check("done_timeout", 1, 0);
      q.delete();
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) ram[i] = 32'(i);
  endtask

  initial begin
    chk_start = '0; chk_post = '0; arr_size[0] = '0; arr_size[1] = '0;
    s0.ar_valid = 1'b0; s0.ar_address = '0; s0.r_ready = 1'b0;
    s1.ar_valid = 1'b0; s1.ar_address = '0; s1.r_ready = 1'b0;
    always_error = 0; ref_sum[0] = 0; ref_sum[1] = 0; busy_q = '0;
    fill_ramp();
    repeat (2) @(negedge clk);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_pass", pass[0], 0);
    check("rst_err_order", err_order[0], 0);
    check("rst_err_sum", err_sum[0], 0);
    check("rst_err_resp", err_resp[0], 0);
    check("rst_fail_idx", fail_idx[0], 0);
    rst_n = 1'b1;
    // sorted data: pre-scan then matching post-scan
    scan(0, 0, 16);
    scan(0, 1, 16);
    // first violation at index 5, scan still reads all words
    ram[5] = 32'd2;
    scan(0, 1, 16);
    ram[5] = 32'd5;
    // sum mismatch with non-decreasing data
    scan(0, 0, 16);
    ram[3] = 32'd4;
    scan(0, 1, 16);
    ram[3] = 32'd3;
    // oversize request clamps to the memory depth
    scan(0, 0, 20);
    // error response aborts after the first beat
    always_error = 1;
    scan(0, 1, 16);
    always_error = 0;
    // signed vs unsigned ordering
    ram[0] = 32'hFFFF_FFFD; ram[1] = 32'hFFFF_FFFF; ram[2] = 32'd0; ram[3] = 32'd7;
    scan(1, 0, 4);
    scan(1, 1, 4);
    scan(0, 1, 4);
    fill_ramp();
    // ownership: sorter read pending when the check is requested
    own_bad = 0;
    @(negedge clk);
    s0.ar_valid = 1'b1; s0.ar_address = 4'd7; s0.r_ready = 1'b0;
    @(negedge clk);
    s0.ar_valid = 1'b0;
    fork
      scan(0, 1, 16);
      begin
        repeat (4) @(negedge clk);
        check("own_wait_busy", busy[0], 0);
        check("own_s_r_valid", s0.r_valid, 1);
        check("own_s_r_data", s0.r_data, 7);
        s0.r_ready = 1'b1;
        @(negedge clk);
        s0.r_ready = 1'b0;
      end
    join
    check("own_sorter_blocked", own_bad, 0);
    // empty array completes immediately
    scan(0, 0, 0);
    // reset mid-scan clears state and the reference sum
    scan(0, 0, 16);
    @(negedge clk);
    chk_start[0] = 1'b1; chk_post[0] = 1'b1; arr_size[0] = 5'd16;
    @(negedge clk);
    chk_start[0] = 1'b0;
    check("mid_busy_before", busy[0], 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_pass", pass[0], 0);
    check("mid_rst_err_order", err_order[0], 0);
    check("mid_rst_done", done[0], 0);
    ref_sum[0] = 0; ref_sum[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    scan(0, 1, 16);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
